// File: rtl/misr_compactor.sv
// misr_compactor: folds a wide response word into a SIG_WIDTH-bit multiple-input
// signature register (Galois form, left shift). A run absorbs exactly NUM_SAMPLES
// valid words, then freezes the signature until the next start.
//
// Handshake: data_in is consumed on every rising edge where the block is in RUN,
// in_valid=1 and start=0. There is no back-pressure; words arriving in IDLE/DONE
// or together with start are dropped.
module misr_compactor #(
   parameter int                   WIDTH       = 128,
   parameter int                   SIG_WIDTH   = 32,
   parameter logic [SIG_WIDTH-1:0] POLY        = 32'h04C11DB7,
   parameter logic [SIG_WIDTH-1:0] SEED        = 32'hFFFFFFFF,
   parameter int                   NUM_SAMPLES = 1024
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               start,
   input  logic                               in_valid,
   input  logic [WIDTH-1:0]                   data_in,
   output logic [SIG_WIDTH-1:0]               signature,
   output logic [$clog2(NUM_SAMPLES+1)-1:0]   sample_count,
   output logic                               busy,
   output logic                               done,
   output logic [1:0]                         dbg_state_o
);

   localparam int CNT_W   = $clog2(NUM_SAMPLES + 1);
   localparam int NSLICES = WIDTH / SIG_WIDTH;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Count value held just before the final accept of a run.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_SAMPLES - 1);

   logic [1:0]           state_q, state_d;
   logic [SIG_WIDTH-1:0] sig_q, sig_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 busy_q, done_q;
   logic [SIG_WIDTH-1:0] fold;
   logic [SIG_WIDTH-1:0] sig_next;

   // XOR all SIG_WIDTH-wide slices of the input word together.
   always_comb begin
      fold = '0;
      for (int i = 0; i < NSLICES; i++) begin
         fold = fold ^ data_in[i*SIG_WIDTH +: SIG_WIDTH];
      end
   end

   // One Galois MISR step; only selected when a word is accepted, so unknowns on
   // an idle data bus never reach the signature register.
   always_comb begin
      sig_next = {sig_q[SIG_WIDTH-2:0], 1'b0}
               ^ (sig_q[SIG_WIDTH-1] ? POLY : '0)
               ^ fold;
   end

   // Next-state logic: run control, signature and sample counter.
   always_comb begin
      state_d = state_q;
      sig_d   = sig_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_RUN;
               sig_d   = SEED;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            if (start) begin
               // Restart drops the word presented in the same cycle.
               sig_d = SEED;
               cnt_d = '0;
            end else if (in_valid) begin
               sig_d = sig_next;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) begin
                  state_d = S_DONE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers; busy/done are registered decodes of the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         sig_q   <= SEED;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sig_q   <= sig_d;
         cnt_q   <= cnt_d;
         busy_q  <= (state_d == S_RUN);
         done_q  <= (state_d == S_DONE);
      end
   end

   assign signature    = sig_q;
   assign sample_count = cnt_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_misr_compactor.sv
// Directed bench for misr_compactor: three instances cover the default
// configuration, NUM_SAMPLES=1, and SEED=0 with NUM_SAMPLES=2.
module tb_misr_compactor;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Default instance
   logic         d_start, d_valid;
   logic [127:0] d_data;
   logic [31:0]  d_sig;
   logic [10:0]  d_cnt;
   logic         d_busy, d_done;
   logic [1:0]   d_state;

   // NUM_SAMPLES=1 instance
   logic         n_start, n_valid;
   logic [127:0] n_data;
   logic [31:0]  n_sig;
   logic [0:0]   n_cnt;
   logic         n_busy, n_done;
   logic [1:0]   n_state;

   // SEED=0, NUM_SAMPLES=2 instance
   logic         s_start, s_valid;
   logic [127:0] s_data;
   logic [31:0]  s_sig;
   logic [1:0]   s_cnt;
   logic         s_busy, s_done;
   logic [1:0]   s_state;

   misr_compactor u_dut (
      .clk(clk), .reset(reset), .start(d_start), .in_valid(d_valid), .data_in(d_data),
      .signature(d_sig), .sample_count(d_cnt), .busy(d_busy), .done(d_done),
      .dbg_state_o(d_state)
   );

   misr_compactor #(.NUM_SAMPLES(1)) u_n1 (
      .clk(clk), .reset(reset), .start(n_start), .in_valid(n_valid), .data_in(n_data),
      .signature(n_sig), .sample_count(n_cnt), .busy(n_busy), .done(n_done),
      .dbg_state_o(n_state)
   );

   misr_compactor #(.SEED(32'h0), .NUM_SAMPLES(2)) u_s0 (
      .clk(clk), .reset(reset), .start(s_start), .in_valid(s_valid), .data_in(s_data),
      .signature(s_sig), .sample_count(s_cnt), .busy(s_busy), .done(s_done),
      .dbg_state_o(s_state)
   );

   // Reference MISR step for the default configuration.
   function automatic logic [31:0] model_step(input logic [31:0] s, input logic [127:0] d);
      logic [31:0] f;
      logic [31:0] r;
      f = d[31:0] ^ d[63:32] ^ d[95:64] ^ d[127:96];
      r = {s[30:0], 1'b0};
      if (s[31]) r = r ^ 32'h04C11DB7;
      return r ^ f;
   endfunction

   // Advance one clock; returns 1 time unit after the rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      d_start = 0; d_valid = 0; d_data = '0;
      n_start = 0; n_valid = 0; n_data = '0;
      s_start = 0; s_valid = 0; s_data = '0;
   endtask

   task automatic test_reset();
      // Get the default instance mid-run, then hit reset for one cycle.
      d_start = 1; cyc(); d_start = 0;
      for (int i = 0; i < 3; i++) begin
         d_valid = 1; d_data = {$urandom, $urandom, $urandom, $urandom}; cyc();
      end
      d_valid = 0;
      reset = 1; cyc(); reset = 0;
      checks++;
      if (d_sig !== 32'hFFFFFFFF) begin errors++; $display("FAIL reset_sig got %h exp %h", d_sig, 32'hFFFFFFFF); end
      checks++;
      if (d_cnt !== 11'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", d_cnt); end
      checks++;
      if (d_busy !== 1'b0 || d_done !== 1'b0 || d_state !== 2'd0) begin
         errors++; $display("FAIL reset_flags got busy=%b done=%b state=%0d exp 0 0 0", d_busy, d_done, d_state);
      end
      // Valid words in IDLE are ignored.
      for (int i = 0; i < 3; i++) begin
         d_valid = 1; d_data = {$urandom, $urandom, $urandom, $urandom}; cyc();
         d_valid = 0; cyc();
      end
      checks++;
      if (d_sig !== 32'hFFFFFFFF || d_cnt !== 11'd0) begin
         errors++; $display("FAIL idle_ignore got sig=%h cnt=%0d exp ffffffff 0", d_sig, d_cnt);
      end
   endtask

   task automatic test_single_sample();
      n_start = 1; cyc(); n_start = 0;
      checks++;
      if (n_busy !== 1'b1 || n_done !== 1'b0 || n_sig !== 32'hFFFFFFFF) begin
         errors++; $display("FAIL n1_armed got busy=%b done=%b sig=%h exp 1 0 ffffffff", n_busy, n_done, n_sig);
      end
      n_valid = 1; n_data = '0; cyc(); n_valid = 0;
      checks++;
      if (n_sig !== 32'hFB3EE249) begin errors++; $display("FAIL n1_sig got %h exp fb3ee249", n_sig); end
      checks++;
      if (n_cnt !== 1'd1 || n_done !== 1'b1 || n_busy !== 1'b0) begin
         errors++; $display("FAIL n1_flags got cnt=%0d done=%b busy=%b exp 1 1 0", n_cnt, n_done, n_busy);
      end
      // Frozen after done.
      n_valid = 1; n_data = {4{32'hDEADBEEF}}; cyc(); n_valid = 0;
      checks++;
      if (n_sig !== 32'hFB3EE249 || n_cnt !== 1'd1) begin
         errors++; $display("FAIL n1_frozen got sig=%h cnt=%0d exp fb3ee249 1", n_sig, n_cnt);
      end
   endtask

   task automatic test_fold();
      s_start = 1; cyc(); s_start = 0;
      s_valid = 1; s_data = {32'h1, 32'h2, 32'h4, 32'h8}; cyc();
      checks++;
      if (s_sig !== 32'h0000000F || s_cnt !== 2'd1 || s_busy !== 1'b1) begin
         errors++; $display("FAIL fold_first got sig=%h cnt=%0d busy=%b exp 0000000f 1 1", s_sig, s_cnt, s_busy);
      end
      s_data = '0; cyc(); s_valid = 0;
      checks++;
      if (s_sig !== 32'h0000001E || s_done !== 1'b1 || s_cnt !== 2'd2) begin
         errors++; $display("FAIL fold_final got sig=%h done=%b cnt=%0d exp 0000001e 1 2", s_sig, s_done, s_cnt);
      end
   endtask

   task automatic test_gaps();
      s_start = 1; cyc(); s_start = 0;
      s_valid = 1; s_data = {32'h1, 32'h2, 32'h4, 32'h8}; cyc();
      for (int i = 0; i < 3; i++) begin
         s_valid = 0; s_data = 'x; cyc();
         checks++;
         if (s_cnt !== 2'd1 || s_busy !== 1'b1 || s_sig !== 32'h0000000F) begin
            errors++; $display("FAIL gap_hold[%0d] got cnt=%0d busy=%b sig=%h exp 1 1 0000000f", i, s_cnt, s_busy, s_sig);
         end
      end
      s_valid = 1; s_data = '0; cyc(); s_valid = 0;
      checks++;
      if (s_sig !== 32'h0000001E || s_cnt !== 2'd2 || s_done !== 1'b1 || s_busy !== 1'b0) begin
         errors++; $display("FAIL gap_final got sig=%h cnt=%0d done=%b busy=%b exp 0000001e 2 1 0", s_sig, s_cnt, s_done, s_busy);
      end
   endtask

   task automatic test_restart();
      logic [31:0]  exp_sig;
      logic [127:0] w;
      d_start = 1; cyc(); d_start = 0;
      d_valid = 1; d_data = {$urandom, $urandom, $urandom, $urandom}; cyc();
      // start together with a valid word: restart, word dropped
      d_start = 1; d_valid = 1; d_data = {$urandom, $urandom, $urandom, $urandom}; cyc();
      d_start = 0; d_valid = 0;
      checks++;
      if (d_sig !== 32'hFFFFFFFF || d_cnt !== 11'd0 || d_busy !== 1'b1 || d_state !== 2'd1) begin
         errors++; $display("FAIL restart got sig=%h cnt=%0d busy=%b state=%0d exp ffffffff 0 1 1", d_sig, d_cnt, d_busy, d_state);
      end
      exp_sig = 32'hFFFFFFFF;
      for (int i = 0; i < 5; i++) begin
         w = {$urandom, $urandom, $urandom, $urandom};
         d_valid = 1; d_data = w; cyc();
         exp_sig = model_step(exp_sig, w);
      end
      d_valid = 0;
      checks++;
      if (d_sig !== exp_sig || d_cnt !== 11'd5) begin
         errors++; $display("FAIL restart_run got sig=%h cnt=%0d exp %h 5", d_sig, d_cnt, exp_sig);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0]  exp_sig;
      logic [31:0]  frozen;
      logic [127:0] w;
      int           n;
      int           bad;
      d_start = 1; cyc(); d_start = 0;
      exp_sig = 32'hFFFFFFFF;
      n = 0;
      bad = 0;
      while (n < 1024) begin
         w = {$urandom, $urandom, $urandom, $urandom};
         d_data = w;
         d_valid = ($urandom_range(0, 7) != 0);
         cyc();
         if (d_valid) begin
            exp_sig = model_step(exp_sig, w);
            n++;
         end
         if (d_sig !== exp_sig && bad < 5) begin
            bad++;
            errors++; $display("FAIL stream_sig[%0d] got %h exp %h", n, d_sig, exp_sig);
         end
         checks++;
      end
      d_valid = 0;
      checks++;
      if (d_done !== 1'b1 || d_busy !== 1'b0 || d_cnt !== 11'd1024) begin
         errors++; $display("FAIL stream_done got done=%b busy=%b cnt=%0d exp 1 0 1024", d_done, d_busy, d_cnt);
      end
      frozen = exp_sig;
      for (int i = 0; i < 50; i++) begin
         d_valid = 1; d_data = {$urandom, $urandom, $urandom, $urandom}; cyc();
      end
      d_valid = 0;
      checks++;
      if (d_sig !== frozen || d_cnt !== 11'd1024 || d_done !== 1'b1) begin
         errors++; $display("FAIL post_done got sig=%h cnt=%0d done=%b exp %h 1024 1", d_sig, d_cnt, d_done, frozen);
      end
      d_start = 1; cyc(); d_start = 0;
      checks++;
      if (d_sig !== 32'hFFFFFFFF || d_cnt !== 11'd0 || d_busy !== 1'b1 || d_done !== 1'b0) begin
         errors++; $display("FAIL rearm got sig=%h cnt=%0d busy=%b done=%b exp ffffffff 0 1 0", d_sig, d_cnt, d_busy, d_done);
      end
   endtask

   initial begin
      idle_all();
      reset = 1;
      cyc(); cyc();
      reset = 0;
      cyc();
      test_reset();
      test_single_sample();
      test_fold();
      test_gaps();
      test_restart();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
